// File: rtl/branch_redirect_ctrl.sv
// Front-end PC redirect arbiter: boot / trap / mispredict / predicted-taken,
// with flush strobes, a post-redirect recovery window, and perf counters.
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          RECOVER_CYCLES = 2,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_mispredict,
    input  logic [31:0]      ex_target,
    input  logic             dec_pred_valid,
    input  logic [31:0]      dec_pred_target,
    input  logic             trap_req,
    input  logic [31:0]      trap_vector,
    input  logic             cnt_clr,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             recovering,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, RECOVER} state_t;

    localparam logic [3:0]  REC_INIT = 4'(RECOVER_CYCLES);
    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFE;

    state_t           state_q, state_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_fd_q, flush_fd_d;
    logic             flush_de_q, flush_de_d;
    logic             flush_em_q, flush_em_d;
    logic             recovering_q, recovering_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        state_d          = state_q;
        rcnt_d           = rcnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_fd_d       = 1'b0;
        flush_de_d       = 1'b0;
        flush_em_d       = 1'b0;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        case (state_q)
            BOOT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = RESET_VECTOR & PC_MASK;
                flush_fd_d       = 1'b1;
                flush_de_d       = 1'b1;
                flush_em_d       = 1'b1;
                state_d          = RUN;
            end
            RUN: begin
                if (ex_valid && ex_is_branch && branch_cnt_q != '1)
                    branch_cnt_d = branch_cnt_q + 1'b1;
                if (trap_req) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = trap_vector & PC_MASK;
                    flush_fd_d       = 1'b1;
                    flush_de_d       = 1'b1;
                    flush_em_d       = 1'b1;
                    rcnt_d           = REC_INIT;
                    state_d          = RECOVER;
                end else if (ex_valid && ex_mispredict) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ex_target & PC_MASK;
                    flush_fd_d       = 1'b1;
                    flush_de_d       = 1'b1;
                    rcnt_d           = REC_INIT;
                    state_d          = RECOVER;
                    if (mispredict_cnt_q != '1)
                        mispredict_cnt_d = mispredict_cnt_q + 1'b1;
                end else if (dec_pred_valid && !stall_f) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = dec_pred_target & PC_MASK;
                    flush_fd_d       = 1'b1;
                end
            end
            RECOVER: begin
                // Wrong-path mispredicts/predictions are dropped; only a trap restarts the window.
                if (trap_req) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = trap_vector & PC_MASK;
                    flush_fd_d       = 1'b1;
                    flush_de_d       = 1'b1;
                    flush_em_d       = 1'b1;
                    rcnt_d           = REC_INIT;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                    if (rcnt_q == 4'd1)
                        state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        if (cnt_clr && state_q != BOOT) begin
            branch_cnt_d     = '0;
            mispredict_cnt_d = '0;
        end

        recovering_d = (state_d == RECOVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= BOOT;
            rcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_VECTOR & PC_MASK;
            flush_fd_q       <= 1'b0;
            flush_de_q       <= 1'b0;
            flush_em_q       <= 1'b0;
            recovering_q     <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            rcnt_q           <= rcnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_fd_q       <= flush_fd_d;
            flush_de_q       <= flush_de_d;
            flush_em_q       <= flush_em_d;
            recovering_q     <= recovering_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_fd       = flush_fd_q;
    assign flush_de       = flush_de_q;
    assign flush_em       = flush_em_q;
    assign recovering     = recovering_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized + directed bench for branch_redirect_ctrl against a cycle-level reference model.
module tb_branch_redirect_ctrl;
    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int CW = 4;
    localparam int RC = 2;

    logic clk = 0, rst = 0;
    logic stall_f = 0, ex_valid = 0, ex_is_branch = 0, ex_mispredict = 0;
    logic [31:0] ex_target = 0, dec_pred_target = 0, trap_vector = 0;
    logic dec_pred_valid = 0, trap_req = 0, cnt_clr = 0;
    logic redirect_valid, flush_fd, flush_de, flush_em, recovering;
    logic [31:0] redirect_pc;
    logic [CW-1:0] branch_cnt, mispredict_cnt;

    int checks = 0, errors = 0;

    // reference model state
    bit m_boot; int m_win; bit m_rv, m_fd, m_de, m_em;
    logic [31:0] m_pc; int m_bcnt, m_mcnt;
    int max_cnt = (1 << CW) - 1;

    branch_redirect_ctrl #(.RESET_VECTOR(RV), .RECOVER_CYCLES(RC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .dec_pred_valid(dec_pred_valid), .dec_pred_target(dec_pred_target),
        .trap_req(trap_req), .trap_vector(trap_vector), .cnt_clr(cnt_clr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_fd(flush_fd),
        .flush_de(flush_de), .flush_em(flush_em), .recovering(recovering),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt));

    always #5 clk = ~clk;

    task automatic model_reset();
        m_boot = 1; m_win = 0; m_rv = 0; m_fd = 0; m_de = 0; m_em = 0;
        m_pc = RV; m_bcnt = 0; m_mcnt = 0;
    endtask

    // What the block should do at the coming edge, given the inputs now applied.
    task automatic model_step();
        bit in_window;
        m_rv = 0; m_fd = 0; m_de = 0; m_em = 0;
        if (m_boot) begin
            m_boot = 0; m_rv = 1; m_pc = RV; m_fd = 1; m_de = 1; m_em = 1;
            return;
        end
        in_window = (m_win > 0);
        if (!in_window && ex_valid && ex_is_branch && m_bcnt < max_cnt) m_bcnt++;
        if (trap_req) begin
            m_rv = 1; m_pc = {trap_vector[31:1], 1'b0}; m_fd = 1; m_de = 1; m_em = 1; m_win = RC;
        end else if (!in_window && ex_valid && ex_mispredict) begin
            m_rv = 1; m_pc = {ex_target[31:1], 1'b0}; m_fd = 1; m_de = 1; m_win = RC;
            if (m_mcnt < max_cnt) m_mcnt++;
        end else if (!in_window && dec_pred_valid && !stall_f) begin
            m_rv = 1; m_pc = {dec_pred_target[31:1], 1'b0}; m_fd = 1;
        end else if (in_window) begin
            m_win--;
        end
        if (cnt_clr) begin m_bcnt = 0; m_mcnt = 0; end
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        stall_f = 0; ex_valid = 0; ex_is_branch = 0; ex_mispredict = 0; ex_target = 0;
        dec_pred_valid = 0; dec_pred_target = 0; trap_req = 0; trap_vector = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 0; model_reset();
        repeat (3) @(posedge clk); #1;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
        checks++; if (redirect_pc !== RV) begin errors++; $display("FAIL reset_pc got %h exp %h", redirect_pc, RV); end
        checks++; if ({flush_fd, flush_de, flush_em, recovering} !== 4'b0) begin errors++; $display("FAIL reset_flush got %b exp 0000", {flush_fd, flush_de, flush_em, recovering}); end
        checks++; if (branch_cnt !== '0 || mispredict_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", branch_cnt, mispredict_cnt); end
        rst = 1;
        ex_valid = 1; ex_mispredict = 1; ex_target = 32'hDEAD_0000; trap_req = 1; // ignored in BOOT
        step(); idle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++; $display("FAIL boot_redirect got %b/%h exp 1/00000100", redirect_valid, redirect_pc); end
        checks++; if ({flush_fd, flush_de, flush_em} !== 3'b111) begin errors++; $display("FAIL boot_flush got %b exp 111", {flush_fd, flush_de, flush_em}); end
        step();
        checks++; if (redirect_valid !== 1'b0 || recovering !== 1'b0) begin errors++; $display("FAIL boot_strobe got %b/%b exp 0/0", redirect_valid, recovering); end
    endtask

    task automatic test_mispredict();
        int mc0 = m_mcnt;
        ex_valid = 1; ex_mispredict = 1; ex_is_branch = 1; ex_target = 32'h0000_2005;
        step(); idle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004) begin errors++; $display("FAIL mis_redirect got %b/%h exp 1/00002004", redirect_valid, redirect_pc); end
        checks++; if ({flush_fd, flush_de, flush_em} !== 3'b110) begin errors++; $display("FAIL mis_flush got %b exp 110", {flush_fd, flush_de, flush_em}); end
        checks++; if (int'(mispredict_cnt) !== mc0 + 1) begin errors++; $display("FAIL mis_cnt got %0d exp %0d", mispredict_cnt, mc0 + 1); end
        checks++; if (recovering !== 1'b1) begin errors++; $display("FAIL mis_rec1 got %b exp 1", recovering); end
        step();
        checks++; if (recovering !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL mis_rec2 got %b/%b exp 1/0", recovering, redirect_valid); end
        step();
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL mis_rec_end got %b exp 0", recovering); end
    endtask

    task automatic test_recover_squash();
        int mc0, bc0;
        ex_valid = 1; ex_mispredict = 1; ex_target = 32'h0000_2000;
        step(); idle();
        mc0 = m_mcnt; bc0 = m_bcnt;
        ex_valid = 1; ex_mispredict = 1; ex_is_branch = 1; ex_target = 32'h3000;
        dec_pred_valid = 1; dec_pred_target = 32'h3100;
        step(); idle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL squash_rv got %b exp 0", redirect_valid); end
        checks++; if (int'(mispredict_cnt) !== mc0 || int'(branch_cnt) !== bc0) begin errors++; $display("FAIL squash_cnt got %0d/%0d exp %0d/%0d", mispredict_cnt, branch_cnt, mc0, bc0); end
        trap_req = 1; trap_vector = 32'h80;
        step(); idle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || {flush_fd, flush_de, flush_em} !== 3'b111) begin errors++; $display("FAIL rec_trap got %b/%h/%b exp 1/00000080/111", redirect_valid, redirect_pc, {flush_fd, flush_de, flush_em}); end
        checks++; if (recovering !== 1'b1) begin errors++; $display("FAIL rec_trap_r1 got %b exp 1", recovering); end
        step();
        checks++; if (recovering !== 1'b1) begin errors++; $display("FAIL rec_trap_r2 got %b exp 1", recovering); end
        step();
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL rec_trap_end got %b exp 0", recovering); end
    endtask

    task automatic test_priority();
        int mc0 = m_mcnt;
        trap_req = 1; trap_vector = 32'h80;
        ex_valid = 1; ex_mispredict = 1; ex_target = 32'h400;
        dec_pred_valid = 1; dec_pred_target = 32'h500;
        step(); idle();
        checks++; if (redirect_pc !== 32'h80 || flush_em !== 1'b1) begin errors++; $display("FAIL prio_trap got %h/%b exp 00000080/1", redirect_pc, flush_em); end
        checks++; if (int'(mispredict_cnt) !== mc0) begin errors++; $display("FAIL prio_cnt got %0d exp %0d", mispredict_cnt, mc0); end
        repeat (RC) step();
    endtask

    task automatic test_pred();
        dec_pred_valid = 1; dec_pred_target = 32'h1000; stall_f = 1;
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL pred_stall got %b exp 0", redirect_valid); end
        stall_f = 0;
        step(); idle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1000) begin errors++; $display("FAIL pred_redirect got %b/%h exp 1/00001000", redirect_valid, redirect_pc); end
        checks++; if ({flush_fd, flush_de, flush_em, recovering} !== 4'b1000) begin errors++; $display("FAIL pred_flush got %b exp 1000", {flush_fd, flush_de, flush_em, recovering}); end
    endtask

    task automatic test_saturate();
        cnt_clr = 1; step(); idle();
        ex_valid = 1; ex_is_branch = 1;
        repeat (20) step();
        checks++; if (branch_cnt !== 4'd15) begin errors++; $display("FAIL sat_branch got %0d exp 15", branch_cnt); end
        cnt_clr = 1;
        step(); idle();
        checks++; if (branch_cnt !== 4'd0) begin errors++; $display("FAIL clr_prio got %0d exp 0", branch_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall_f        = ($urandom_range(0, 9) < 3);
            ex_valid       = ($urandom_range(0, 9) < 7);
            ex_is_branch   = $urandom_range(0, 1);
            ex_mispredict  = ($urandom_range(0, 9) < 2);
            ex_target      = $urandom;
            dec_pred_valid = ($urandom_range(0, 9) < 3);
            dec_pred_target = $urandom;
            trap_req       = ($urandom_range(0, 19) == 0);
            trap_vector    = $urandom;
            cnt_clr        = ($urandom_range(0, 49) == 0);
            step();
            checks++;
            if ({redirect_valid, flush_fd, flush_de, flush_em, recovering} !== {m_rv, m_fd, m_de, m_em, m_win > 0} ||
                (m_rv && redirect_pc !== m_pc) || int'(branch_cnt) !== m_bcnt || int'(mispredict_cnt) !== m_mcnt) begin
                errors++;
                $display("FAIL rand[%0d] got rv%b pc%h f%b%b%b r%b b%0d m%0d exp rv%b pc%h f%b%b%b r%b b%0d m%0d", i,
                    redirect_valid, redirect_pc, flush_fd, flush_de, flush_em, recovering, branch_cnt, mispredict_cnt,
                    m_rv, m_pc, m_fd, m_de, m_em, m_win > 0, m_bcnt, m_mcnt);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_recover();
        repeat (RC + 1) step();
        ex_valid = 1; ex_mispredict = 1; ex_target = 32'h4000;
        step(); idle();
        #2 rst = 0; #1;
        checks++; if (recovering !== 1'b0 || redirect_valid !== 1'b0 || {flush_fd, flush_de, flush_em} !== 3'b0) begin errors++; $display("FAIL async_rst got r%b rv%b f%b exp 0/0/000", recovering, redirect_valid, {flush_fd, flush_de, flush_em}); end
        checks++; if (redirect_pc !== RV || mispredict_cnt !== '0) begin errors++; $display("FAIL async_rst_pc got %h/%0d exp %h/0", redirect_pc, mispredict_cnt, RV); end
        repeat (2) @(posedge clk); #1;
        rst = 1; model_reset();
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== RV || {flush_fd, flush_de, flush_em} !== 3'b111) begin errors++; $display("FAIL reboot got %b/%h/%b exp 1/%h/111", redirect_valid, redirect_pc, {flush_fd, flush_de, flush_em}, RV); end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_recover_squash();
        test_priority();
        test_pred();
        test_saturate();
        test_random();
        test_reset_mid_recover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Front-end PC redirect controller/scheduler. It arbitrates all PC-redirect requests: boot vector, trap, execute-stage branch mispredict, and decode-stage predicted-taken jump/branch.
- Issues one registered redirect plus per-stage flush strobes, then holds a recovery window that squashes wrong-path requests.
- Sits between the branch predictor/hazard unit and the fetch PC register, and keeps branch/mispredict performance counters.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC issued on the first cycle after reset release.
- RECOVER_CYCLES, 2, cycles in RECOVER after a mispredict or trap redirect (1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_f  in  1  fetch stall from hazard unit.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_is_branch  in  1  execute instruction is a conditional branch, JAL or JALR.
- ex_mispredict  in  1  execute resolved differently from prediction; qualified by ex_valid.
- ex_target  in  32  correct PC for a mispredict.
- dec_pred_valid  in  1  decode predicts a taken redirect.
- dec_pred_target  in  32  predicted target.
- trap_req  in  1  trap/exception request.
- trap_vector  in  32  trap handler PC.
- cnt_clr  in  1  synchronous clear of both counters.
- redirect_valid  out  1  load redirect_pc into the fetch PC this cycle.
- redirect_pc  out  32  redirect target, bit 0 always 0.
- flush_fd  out  1  flush IF/ID.
- flush_de  out  1  flush ID/EX.
- flush_em  out  1  flush EX/MEM (trap and boot only).
- recovering  out  1  high while in RECOVER.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispredict_cnt  out  CNT_W  accepted mispredicts, saturating.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - state=BOOT.
  - redirect_valid, all flushes, recovering = 0.
  - redirect_pc=RESET_VECTOR.
  - Counters = 0.
  - Recovery counter = 0.
- All outputs are registered. A request sampled at edge N produces its response in the cycle after edge N. Redirect and flush strobes are exactly 1 cycle wide.
- BOOT: at the first edge with rst=1, assert redirect_valid=1, redirect_pc=RESET_VECTOR, flush_fd=flush_de=flush_em=1. Go to RUN. Inputs are ignored in BOOT.
- RUN, arbitration priority trap > mispredict > prediction:
  - trap_req: redirect to trap_vector with all three flushes. Load the recovery counter with RECOVER_CYCLES and go to RECOVER.
  - ex_valid & ex_mispredict: redirect to ex_target with flush_fd=flush_de=1 and flush_em=0. Load the counter and go to RECOVER.
  - dec_pred_valid & !stall_f: redirect to dec_pred_target with flush_fd=1 only. Stay in RUN. While stall_f=1 the prediction is dropped; decode re-presents it.
  - Otherwise: redirect_valid=0 and flushes=0.
- RECOVER:
  - recovering=1.
  - ex_mispredict and dec_pred_valid are ignored (wrong path).
  - trap_req is still accepted: redirect as in RUN and reload the counter.
  - Otherwise the counter decrements each cycle. Leave for RUN on the edge where it reads 1, so recovering stays high for exactly RECOVER_CYCLES cycles.
- A trap and a mispredict in the same cycle: trap wins, and the mispredict is not counted.
- redirect_pc = selected target & 32'hFFFF_FFFE.
- Counters:
  - branch_cnt increments on ex_valid & ex_is_branch in RUN only.
  - mispredict_cnt increments on each accepted mispredict.
  - Both saturate at all-ones and do not wrap.
  - cnt_clr has priority over increment in the same cycle.
- Reset asserted mid-RECOVER or during a strobe: all outputs return immediately to reset values, and the state returns to BOOT.

Test Plan:
- Reset release with RESET_VECTOR=32'h0000_0100 -> the cycle after the first edge shows redirect_valid=1, redirect_pc=0x100, all flushes=1. The following cycle shows redirect_valid=0.
- RUN, ex_valid=1, ex_mispredict=1, ex_target=0x0000_2005 -> next cycle: redirect_pc=0x2004, flush_fd=flush_de=1, flush_em=0, mispredict_cnt=1. recovering=1 for exactly 2 cycles.
- During RECOVER, a mispredict to 0x3000 plus dec_pred_valid -> no redirect, counters unchanged. A trap_req in the same window with trap_vector=0x80 -> redirect to 0x80 with all flushes, and the window restarts at 2 cycles.
- Same cycle: trap_req to 0x80, mispredict to 0x400, dec_pred to 0x500 -> redirect_pc=0x80, flush_em=1, mispredict_cnt unchanged.
- dec_pred_valid=1, target 0x1000:
  - With stall_f=1 -> no redirect.
  - With stall_f=0 -> redirect_pc=0x1000, flush_fd=1, flush_de=0, state stays RUN.
- CNT_W=4: drive 20 RUN branch resolutions -> branch_cnt stops at 15. Then cnt_clr together with a branch -> branch_cnt=0. Asserting reset mid-RECOVER -> recovering=0 immediately, and the BOOT redirect is reissued after release.
